// File: rtl/vote_session_ctrl_if.sv
// Ballot-session bus: voter handshake, status and verdict handshake.
// The slave modport is the controller's view; master is the environment's.
interface vote_session_ctrl_if;
  logic       start;
  logic [3:0] vote_valid;
  logic [3:0] vote_val;
  logic [3:0] vote_ack;
  logic       busy;
  logic [3:0] voted;
  logic       result_valid;
  logic       result_ready;
  logic [2:0] result;
  logic [2:0] yes_count;
  logic       timed_out;

  modport slave (
    input  start, vote_valid, vote_val, result_ready,
    output vote_ack, busy, voted, result_valid, result, yes_count, timed_out
  );

  modport master (
    output start, vote_valid, vote_val, result_ready,
    input  vote_ack, busy, voted, result_valid, result, yes_count, timed_out
  );
endinterface

// File: rtl/vote_session_ctrl.sv
// Four-voter ballot session sequencer: collects one ballot per voter,
// closes on full quorum or timeout, and holds a one-hot verdict until it is accepted.
//
// state   | meaning
// IDLE    | waiting for start; last verdict still visible
// COLLECT | accepting ballots, timer running
// TALLY   | one cycle to count yes ballots and form the verdict
// DONE    | verdict valid, waiting for result_ready
module vote_session_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TMR_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  vote_session_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_TALLY   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [3:0]        voted_q, voted_d;
  logic [3:0]        ballot_q, ballot_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              timed_out_q, timed_out_d;
  logic [2:0]        result_q, result_d;
  logic [2:0]        yes_q, yes_d;
  logic [3:0]        ack;
  logic [2:0]        yes_tally;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Non-voters have ballot 0 after the clear, but masking keeps the intent explicit.
  assign yes_tally = popcnt4(ballot_q & voted_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      voted_q     <= '0;
      ballot_q    <= '0;
      timer_q     <= '0;
      timed_out_q <= 1'b0;
      result_q    <= '0;
      yes_q       <= '0;
    end else begin
      state_q     <= state_d;
      voted_q     <= voted_d;
      ballot_q    <= ballot_d;
      timer_q     <= timer_d;
      timed_out_q <= timed_out_d;
      result_q    <= result_d;
      yes_q       <= yes_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    voted_d     = voted_q;
    ballot_d    = ballot_q;
    timer_d     = timer_q;
    timed_out_d = timed_out_q;
    result_d    = result_q;
    yes_d       = yes_q;
    ack         = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_COLLECT;
          voted_d     = '0;
          ballot_d    = '0;
          timer_d     = '0;
          timed_out_d = 1'b0;
          result_d    = '0;
          yes_d       = '0;
        end
      end

      S_COLLECT: begin
        ack      = bus.vote_valid & ~voted_q;
        voted_d  = voted_q | ack;
        ballot_d = (ballot_q & ~ack) | (bus.vote_val & ack);
        // Quorum wins over timeout; timer stops at its last value on exit.
        if ((voted_q | ack) == 4'b1111) begin
          state_d     = S_TALLY;
          timed_out_d = 1'b0;
        end else if (timer_q == TMR_LAST) begin
          state_d     = S_TALLY;
          timed_out_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_TALLY: begin
        yes_d = yes_tally;
        if (yes_tally >= 3'd3)      result_d = 3'b100;
        else if (yes_tally == 3'd2) result_d = 3'b010;
        else                        result_d = 3'b001;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (bus.result_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.vote_ack     = ack;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.voted        = voted_q;
  assign bus.result_valid = (state_q == S_DONE);
  assign bus.result       = result_q;
  assign bus.yes_count    = yes_q;
  assign bus.timed_out    = timed_out_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: table of ballot sessions with a verdict scoreboard,
// plus hand sequences for start-in-DONE and asynchronous reset mid-session.
module tb_vote_session_ctrl;

  logic clk;
  logic rst_n;

  vote_session_ctrl_if vif ();

  vote_session_ctrl #(.TIMEOUT(16), .TMR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] cyc;   // COLLECT cycle index where voter i first raises valid
    logic [3:0][3:0] hold;  // cycles valid stays high (later cycles present ~val)
    logic [3:0]      val;
    int              n;     // expected COLLECT cycles
    logic [2:0]      res;
    logic [2:0]      yes;
    logic            to;
    logic [3:0]      voted;
    int              rdy;   // DONE cycles before result_ready
  } vec_t;

  typedef struct {
    logic [2:0] res;
    logic [2:0] yes;
    logic       to;
    logic [3:0] voted;
  } exp_t;

  vec_t tbl [8];
  exp_t sb_q [$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endtask

  task automatic run_session(input vec_t r);
    exp_t       e;
    int         cyc;
    int         lat;
    logic [3:0] vv, vl, mv, ea;
    e.res = r.res; e.yes = r.yes; e.to = r.to; e.voted = r.voted;
    sb_q.push_back(e);
    @(negedge clk);
    vif.start = 1'b1; vif.vote_valid = '0;
    @(negedge clk);
    vif.start = 1'b0;
    mv = '0; cyc = 0; lat = 0;
    while (!vif.result_valid && lat < 64) begin
      vv = '0; vl = '0;
      for (int i = 0; i < 4; i++) begin
        if (cyc >= int'(r.cyc[i]) && cyc < int'(r.cyc[i]) + int'(r.hold[i])) begin
          vv[i] = 1'b1;
          vl[i] = (cyc == int'(r.cyc[i])) ? r.val[i] : ~r.val[i];
        end
      end
      vif.vote_valid = vv; vif.vote_val = vl;
      #1;
      ea = (cyc < r.n) ? (vv & ~mv) : 4'b0000;
      chk("vote_ack", vif.vote_ack, ea);
      mv = mv | ea;
      @(negedge clk);
      cyc++; lat++;
    end
    vif.vote_valid = '0;
    chk("latency", lat, r.n + 1);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk("result_valid", vif.result_valid, 1);
      chk("result", vif.result, e.res);
      chk("yes_count", vif.yes_count, e.yes);
      chk("timed_out", vif.timed_out, e.to);
      chk("voted", vif.voted, e.voted);
      for (int d = 0; d < r.rdy; d++) begin
        chk("rv_held", vif.result_valid, 1);
        chk("result_held", vif.result, e.res);
        @(negedge clk);
      end
      vif.result_ready = 1'b1;
      @(negedge clk);
      vif.result_ready = 1'b0;
      chk("idle_busy", vif.busy, 0);
      chk("idle_rv", vif.result_valid, 0);
      chk("idle_result", vif.result, e.res);
      chk("idle_yes", vif.yes_count, e.yes);
    end
  endtask

  initial begin
    tbl[0] = '{cyc:{8'd0,8'd0,8'd0,8'd0}, hold:{4'd1,4'd1,4'd1,4'd1}, val:4'b1011,
               n:1, res:3'b100, yes:3'd3, to:1'b0, voted:4'hF, rdy:0};
    tbl[1] = '{cyc:{8'd7,8'd5,8'd7,8'd2}, hold:{4'd1,4'd1,4'd1,4'd1}, val:4'b0101,
               n:8, res:3'b010, yes:3'd2, to:1'b0, voted:4'hF, rdy:4};
    tbl[2] = '{cyc:{8'd255,8'd255,8'd3,8'd255}, hold:{4'd1,4'd1,4'd1,4'd1}, val:4'b0010,
               n:16, res:3'b001, yes:3'd1, to:1'b1, voted:4'b0010, rdy:1};
    tbl[3] = '{cyc:{8'd15,8'd0,8'd0,8'd0}, hold:{4'd1,4'd1,4'd1,4'd1}, val:4'b0000,
               n:16, res:3'b001, yes:3'd0, to:1'b0, voted:4'hF, rdy:0};
    tbl[4] = '{cyc:{8'd255,8'd255,8'd255,8'd255}, hold:{4'd1,4'd1,4'd1,4'd1}, val:4'b0000,
               n:16, res:3'b001, yes:3'd0, to:1'b1, voted:4'b0000, rdy:2};
    tbl[5] = '{cyc:{8'd9,8'd3,8'd3,8'd1}, hold:{4'd1,4'd1,4'd1,4'd1}, val:4'b1111,
               n:10, res:3'b100, yes:3'd4, to:1'b0, voted:4'hF, rdy:0};
    tbl[6] = '{cyc:{8'd16,8'd255,8'd0,8'd0}, hold:{4'd1,4'd1,4'd1,4'd1}, val:4'b1011,
               n:16, res:3'b010, yes:3'd2, to:1'b1, voted:4'b0011, rdy:1};
    tbl[7] = '{cyc:{8'd3,8'd3,8'd3,8'd0}, hold:{4'd1,4'd1,4'd1,4'd3}, val:4'b0001,
               n:4, res:3'b001, yes:3'd1, to:1'b0, voted:4'hF, rdy:0};

    rst_n = 1'b0;
    vif.start = 1'b0; vif.vote_valid = 4'hF; vif.vote_val = 4'hF; vif.result_ready = 1'b0;
    #3;
    chk("rst_busy", vif.busy, 0);
    chk("rst_ack", vif.vote_ack, 0);
    chk("rst_rv", vif.result_valid, 0);
    chk("rst_result", vif.result, 0);
    chk("rst_yes", vif.yes_count, 0);
    chk("rst_to", vif.timed_out, 0);
    chk("rst_voted", vif.voted, 0);
    @(negedge clk);
    rst_n = 1'b1; vif.vote_valid = '0; vif.vote_val = '0;

    for (int k = 0; k < 8; k++) run_session(tbl[k]);

    // start held during DONE must not open a new session
    @(negedge clk);
    vif.start = 1'b1;
    @(negedge clk);
    vif.start = 1'b0; vif.vote_valid = 4'hF; vif.vote_val = 4'b0110;
    #1 chk("sd_ack", vif.vote_ack, 4'hF);
    @(negedge clk);
    vif.vote_valid = '0;
    chk("sd_tally_ack", vif.vote_ack, 0);
    @(negedge clk);
    chk("sd_rv", vif.result_valid, 1);
    vif.start = 1'b1;
    @(negedge clk);
    chk("sd_still_done", vif.result_valid, 1);
    chk("sd_busy", vif.busy, 1);
    vif.result_ready = 1'b1; vif.start = 1'b0;
    @(negedge clk);
    vif.result_ready = 1'b0;
    chk("sd_idle", vif.busy, 0);
    chk("sd_result", vif.result, 3'b010);
    chk("sd_yes", vif.yes_count, 2);
    @(negedge clk);
    chk("sd_no_restart", vif.busy, 0);

    // asynchronous reset in the middle of COLLECT
    @(negedge clk);
    vif.start = 1'b1;
    @(negedge clk);
    vif.start = 1'b0; vif.vote_valid = 4'b0001; vif.vote_val = 4'b0001;
    @(negedge clk);
    vif.vote_valid = '0;
    chk("ar_pre_voted", vif.voted, 4'b0001);
    chk("ar_pre_busy", vif.busy, 1);
    #2;
    rst_n = 1'b0; vif.vote_valid = 4'hF;
    #1;
    chk("ar_busy", vif.busy, 0);
    chk("ar_ack", vif.vote_ack, 0);
    chk("ar_voted", vif.voted, 0);
    chk("ar_result", vif.result, 0);
    chk("ar_yes", vif.yes_count, 0);
    chk("ar_to", vif.timed_out, 0);
    chk("ar_rv", vif.result_valid, 0);
    @(negedge clk);
    rst_n = 1'b1; vif.vote_valid = '0;
    @(negedge clk);
    chk("ar_stays_idle", vif.busy, 0);

    run_session(tbl[0]);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
